// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: load-type encodings and the MEM/WB register layout.
package mem_pkg;

    localparam logic [1:0] LM_WORD  = 2'b00;
    localparam logic [1:0] LM_HALF  = 2'b01;
    localparam logic [1:0] LM_BYTE  = 2'b10;
    localparam logic [1:0] LM_BYTEU = 2'b11;

    typedef struct packed {
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] address;
    } mem_wb_t;

endpackage

// File: rtl/mem_data_ram.sv
// Word-organised data RAM: synchronous word write, combinational word read, no reset.
module mem_data_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    // Read is asynchronous, so a same-edge store is seen only after the edge.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_access_wb.sv
// MEM stage with data RAM, sub-word load extension and the MEM/WB pipeline register.
module mem_access_wb
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  load_mode,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic [4:0]  write_back_destination,
    output logic [4:0]  wb_write_back_destination,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_address
);

    logic [31:0] word;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [31:0] load_data;
    logic        ram_we;
    mem_wb_t     wb_q;
    mem_wb_t     wb_d;

    // Stores are word-aligned; address[1:0] never reaches the RAM.
    assign ram_we = mem_write & rst_n;

    mem_data_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (address[ADDR_WIDTH+1:2]),
        .wdata (write_data),
        .rdata (word)
    );

    always_comb begin
        half      = address[1] ? word[31:16] : word[15:0];
        byte_sel  = word[{address[1:0], 3'b000} +: 8];
        load_data = '0;
        if (mem_read) begin
            case (load_mode)
                LM_WORD:  load_data = word;
                LM_HALF:  load_data = {{16{half[15]}}, half};
                LM_BYTE:  load_data = {{24{byte_sel[7]}}, byte_sel};
                LM_BYTEU: load_data = {24'h0, byte_sel};
                default:  load_data = '0;
            endcase
        end
    end

    always_comb begin
        wb_d            = '0;
        wb_d.dest       = write_back_destination;
        wb_d.reg_write  = reg_write;
        wb_d.mem_to_reg = mem_to_reg;
        wb_d.read_data  = load_data;
        wb_d.address    = address;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_q <= '0;
        else        wb_q <= wb_d;
    end

    assign wb_write_back_destination = wb_q.dest;
    assign wb_reg_write              = wb_q.reg_write;
    assign wb_mem_to_reg             = wb_q.mem_to_reg;
    assign wb_read_data              = wb_q.read_data;
    assign wb_address                = wb_q.address;

endmodule

// File: tb/tb_mem_access_wb.sv
// Directed bench for mem_access_wb: loads, stores, extension, collisions, wrap and async reset.
module tb_mem_access_wb;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  load_mode = 2'b00;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        reg_write = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic [4:0]  write_back_destination = '0;
    logic [4:0]  wb_write_back_destination;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [31:0] wb_read_data;
    logic [31:0] wb_address;

    int tests = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    mem_access_wb #(.ADDR_WIDTH(8)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .mem_read                  (mem_read),
        .mem_write                 (mem_write),
        .load_mode                 (load_mode),
        .address                   (address),
        .write_data                (write_data),
        .reg_write                 (reg_write),
        .mem_to_reg                (mem_to_reg),
        .write_back_destination    (write_back_destination),
        .wb_write_back_destination (wb_write_back_destination),
        .wb_reg_write              (wb_reg_write),
        .wb_mem_to_reg             (wb_mem_to_reg),
        .wb_read_data              (wb_read_data),
        .wb_address                (wb_address)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] lm,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic rw, input logic m2r, input logic [4:0] d);
        mem_read = rd; mem_write = wr; load_mode = lm; address = a;
        write_data = wd; reg_write = rw; mem_to_reg = m2r; write_back_destination = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".rd"},   wb_read_data, 32'h0);
        check({tag, ".addr"}, wb_address, 32'h0);
        check({tag, ".dest"}, {27'h0, wb_write_back_destination}, 32'h0);
        check({tag, ".ctl"},  {30'h0, wb_reg_write, wb_mem_to_reg}, 32'h0);
    endtask

    // One load at a time: drive, clock, compare extended data and pass-through address.
    task automatic load(input string tag, input logic [1:0] lm, input logic [31:0] a,
                        input logic [31:0] exp);
        drive(1'b1, 1'b0, lm, a, 32'h0, 1'b1, 1'b1, 5'd7);
        tick();
        check(tag, wb_read_data, exp);
        check({tag, ".addr"}, wb_address, a);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd);
        drive(1'b0, 1'b1, LM_WORD, a, wd, 1'b0, 1'b0, 5'd0);
        tick();
    endtask

    initial begin
        // Reset held with random activity, including stores that must be suppressed.
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                  5'($urandom_range(0, 31)));
            tick();
            check_zero("rst_hold");
        end

        // First edge after release captures the inputs (a store with no read).
        drive(1'b0, 1'b1, LM_WORD, 32'h10, 32'h8899AABB, 1'b0, 1'b1, 5'd3);
        rst_n = 1'b1;
        tick();
        check("first.addr", wb_address, 32'h10);
        check("first.dest", {27'h0, wb_write_back_destination}, 32'd3);
        check("first.rd",   wb_read_data, 32'h0);
        check("first.m2r",  {31'h0, wb_mem_to_reg}, 32'h1);

        drive(1'b1, 1'b0, LM_WORD, 32'h10, 32'h0, 1'b1, 1'b1, 5'd5);
        tick();
        check("lw.rd",   wb_read_data, 32'h8899AABB);
        check("lw.addr", wb_address, 32'h10);
        check("lw.dest", {27'h0, wb_write_back_destination}, 32'd5);
        check("lw.rw",   {31'h0, wb_reg_write}, 32'h1);
        check("lw.m2r",  {31'h0, wb_mem_to_reg}, 32'h1);

        load("lh12",  LM_HALF,  32'h12, 32'hFFFF8899);
        load("lh10",  LM_HALF,  32'h10, 32'hFFFFAABB);
        load("lh13",  LM_HALF,  32'h13, 32'hFFFF8899);
        load("lb11",  LM_BYTE,  32'h11, 32'hFFFFFFAA);
        load("lb10",  LM_BYTE,  32'h10, 32'hFFFFFFBB);
        load("lbu11", LM_BYTEU, 32'h11, 32'h000000AA);
        load("lbu13", LM_BYTEU, 32'h13, 32'h00000088);
        load("lw13",  LM_WORD,  32'h13, 32'h8899AABB);

        // Misaligned store address still writes the whole aligned word.
        store(32'h23, 32'h00007F01);
        load("lb21",  LM_BYTE,  32'h21, 32'h0000007F);
        load("lbu20", LM_BYTEU, 32'h20, 32'h00000001);
        load("lw20",  LM_WORD,  32'h20, 32'h00007F01);

        drive(1'b0, 1'b0, LM_WORD, 32'h10, 32'h0, 1'b1, 1'b0, 5'd9);
        tick();
        check("noread.rd",   wb_read_data, 32'h0);
        check("noread.addr", wb_address, 32'h10);
        check("noread.m2r",  {31'h0, wb_mem_to_reg}, 32'h0);

        // Same-word load and store at one edge returns the old word.
        drive(1'b1, 1'b1, LM_WORD, 32'h10, 32'h12345678, 1'b1, 1'b1, 5'd5);
        tick();
        check("coll.old", wb_read_data, 32'h8899AABB);
        load("coll.new", LM_WORD, 32'h10, 32'h12345678);

        store(32'h400, 32'hCAFEF00D);
        load("wrap", LM_WORD, 32'h0, 32'hCAFEF00D);

        // Async reset between edges clears outputs without touching RAM.
        load("pre_rst", LM_WORD, 32'h20, 32'h00007F01);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        drive(1'b1, 1'b1, LM_WORD, 32'h20, 32'hDEADBEEF, 1'b1, 1'b1, 5'd31);
        tick();
        check_zero("rst_edge");
        rst_n = 1'b1;
        load("post_rst20", LM_WORD, 32'h20, 32'h00007F01);
        load("post_rst0",  LM_WORD, 32'h0,  32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_wb.md
# mem_access_wb

Memory-access and MEM/WB boundary block of the five-stage MIPS pipeline. It holds a byte-addressed, word-organised data RAM. It performs word stores and word/halfword/byte loads with sign or zero extension. It registers the load result, the ALU address and the write-back control fields into the MEM/WB pipeline register that feeds the write-back stage.

## Interface
Parameters:
- ADDR_WIDTH, default 8: word-index bits; the RAM holds 2^ADDR_WIDTH 32-bit words (1 KiB by default).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- mem_read  input  1  load enable for the current MEM-stage instruction.
- mem_write  input  1  store-word enable.
- load_mode  input  2  load type: 00 word, 01 halfword signed, 10 byte signed, 11 byte unsigned.
- address  input  32  byte address (ALU result).
- write_data  input  32  store data.
- reg_write  input  1  write-back register-write enable.
- mem_to_reg  input  1  write-back source select (1 = memory data).
- write_back_destination  input  5  destination register number.
- wb_write_back_destination  output  5  registered destination.
- wb_reg_write  output  1  registered reg_write.
- wb_mem_to_reg  output  1  registered mem_to_reg.
- wb_read_data  output  32  registered extended load data.
- wb_address  output  32  registered address (ALU result pass-through).

## Operation
- The word index is address[ADDR_WIDTH+1:2]; upper address bits are ignored, so accesses wrap modulo the RAM size.
- Memory is little-endian: byte address[1:0]=0 is bits 7:0 of the word.
- Store: when mem_write=1, the full write_data word is written to the indexed word. address[1:0] is ignored, so stores are forced word-aligned. There are no sub-word stores.
- Load data is formed combinationally from the indexed word:
  - word: the whole word; address[1:0] ignored.
  - halfword signed: half selected by address[1]; address[0] ignored; bit 15 replicated into bits 31:16.
  - byte signed: byte selected by address[1:0]; bit 7 sign-extended.
  - byte unsigned: byte selected by address[1:0]; zero-extended.
- When mem_read=0, the load value is 32'h0.
- mem_read=1 together with mem_write=1 is legal. Both actions occur, and the load returns the pre-write contents.
- RAM contents are not reset and are undefined until written.

## Timing
- Stores commit on the rising edge of clk when mem_write=1 and rst_n=1.
- The MEM/WB register captures all five fields on every rising edge while rst_n=1. There is no stall or flush input.
- Latency: inputs presented before edge N appear on the wb_* outputs after edge N (1 cycle).
- Read-before-write: a load and a store to the same word at the same edge capture the old word into wb_read_data. The new word is visible from the next cycle.
- Reset: asserting rst_n low immediately (asynchronously) drives all wb_* outputs to 0. Stores are suppressed while rst_n=0. Deassertion takes effect at the next rising edge. Reset mid-sequence leaves RAM contents unchanged.

## Structure
- Shared package mem_pkg holds the load_mode constants LM_WORD=2'b00, LM_HALF=2'b01, LM_BYTE=2'b10, LM_BYTEU=2'b11.
- Sub-module mem_data_ram contains the storage array, the synchronous word write and the combinational word read.
- The top contains the lane select, sign/zero extension, and the MEM/WB register.

## Test plan
- Reset: hold rst_n=0 with random inputs and clocking. All wb_* outputs stay 0. Release rst_n, and the first edge captures the inputs.
- Word store/load: sw 0x8899AABB to 0x10; then lw at 0x10 with mem_read=1, reg_write=1, mem_to_reg=1, dest=5. After one edge: wb_read_data=0x8899AABB, wb_address=0x10, wb_write_back_destination=5, wb_reg_write=1, wb_mem_to_reg=1.
- Sub-word loads on that word:
  - halfword signed at 0x12 gives 0xFFFF8899.
  - halfword signed at 0x10 gives 0xFFFFAABB.
  - byte signed at 0x11 gives 0xFFFFFFAA.
  - byte unsigned at 0x11 gives 0x000000AA.
  - write 0x00007F01 to 0x20, then byte signed at 0x21 gives 0x0000007F.
- Read disabled: mem_read=0 at 0x10 gives wb_read_data=0, while wb_address=0x10 still passes through.
- Same-word collision: word 0x10 holds 0x8899AABB; at one edge, store 0x12345678 to 0x10 with lw at 0x10. wb_read_data=0x8899AABB; the next lw returns 0x12345678.
- Wrap and async reset:
  - With ADDR_WIDTH=8, a store to 0x400 followed by a load from 0x0 returns the stored word.
  - Pulse rst_n low between edges: outputs clear to 0 immediately, and RAM data is still readable afterwards.
